// File: rtl/matrix_coef_loader.sv
// Colour-matrix coefficient loader: serial two's-complement writes into a shadow bank, committed on frame_sync.
// Optional readback port is enabled by defining MATRIX_COEF_READBACK_EN.
module matrix_coef_loader #(
  parameter int               MSIZE     = 8,
  parameter logic [MSIZE-1:0] DIAG_INIT = 8'h7F
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [MSIZE-1:0] wr_data,
  input  logic             wr_abort,
  input  logic             frame_sync,
`ifdef MATRIX_COEF_READBACK_EN
  input  logic [3:0]       rd_idx,
  output logic [MSIZE-1:0] rd_data,
`endif
  output logic [MSIZE-1:0] M00,
  output logic [MSIZE-1:0] M01,
  output logic [MSIZE-1:0] M02,
  output logic [MSIZE-1:0] M10,
  output logic [MSIZE-1:0] M11,
  output logic [MSIZE-1:0] M12,
  output logic [MSIZE-1:0] M20,
  output logic [MSIZE-1:0] M21,
  output logic [MSIZE-1:0] M22,
  output logic             commit,
  output logic             set_full,
  output logic             sat_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [MSIZE-1:0] MOST_NEG = {1'b1, {(MSIZE-1){1'b0}}};

  state_t           state_q;
  logic [3:0]       index_q;
  logic [MSIZE-1:0] shadow_q [9];
  logic [MSIZE-1:0] active_q [9];
  logic             wr_ready_q;
  logic             set_full_q;
  logic             commit_q;
  logic             sat_q;
  logic             wr_accept;
  logic [MSIZE-1:0] wr_sm;

  // Two's complement to sign-magnitude; the most negative value saturates to -(2^(MSIZE-1)-1).
  function automatic logic [MSIZE-1:0] to_sm(input logic [MSIZE-1:0] x);
    logic [MSIZE-1:0] neg;
    neg = -x;
    if (!x[MSIZE-1]) begin
      to_sm = x;
    end else if (x == MOST_NEG) begin
      to_sm = {1'b1, {(MSIZE-1){1'b1}}};
    end else begin
      to_sm = {1'b1, neg[MSIZE-2:0]};
    end
  endfunction

  assign wr_accept = wr_valid & wr_ready_q & ~wr_abort;
  assign wr_sm     = to_sm(wr_data);

  // Load FSM, shadow/active banks and all status outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      index_q    <= 4'd0;
      wr_ready_q <= 1'b1;
      set_full_q <= 1'b0;
      commit_q   <= 1'b0;
      sat_q      <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= {MSIZE{1'b0}};
        active_q[i] <= (i == 0 || i == 4 || i == 8) ? DIAG_INIT : {MSIZE{1'b0}};
      end
    end else begin
      commit_q <= 1'b0;
      if (wr_accept && (wr_data == MOST_NEG)) begin
        sat_q <= 1'b1;
      end
      if (wr_accept) begin
        for (int i = 0; i < 9; i++) begin
          if (index_q == 4'(i)) begin
            shadow_q[i] <= wr_sm;
          end
        end
      end
      // Abort overrides both loading and a coincident commit.
      if (wr_abort) begin
        state_q    <= ST_IDLE;
        index_q    <= 4'd0;
        wr_ready_q <= 1'b1;
        set_full_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (wr_accept) begin
              state_q <= ST_LOAD;
              index_q <= 4'd1;
            end
          end
          ST_LOAD: begin
            if (wr_accept) begin
              if (index_q == 4'd8) begin
                state_q    <= ST_FULL;
                index_q    <= 4'd0;
                wr_ready_q <= 1'b0;
                set_full_q <= 1'b1;
              end else begin
                index_q <= index_q + 4'd1;
              end
            end
          end
          ST_FULL: begin
            if (frame_sync) begin
              for (int i = 0; i < 9; i++) begin
                active_q[i] <= shadow_q[i];
              end
              commit_q   <= 1'b1;
              state_q    <= ST_IDLE;
              wr_ready_q <= 1'b1;
              set_full_q <= 1'b0;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            index_q    <= 4'd0;
            wr_ready_q <= 1'b1;
            set_full_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MATRIX_COEF_READBACK_EN
  logic [MSIZE-1:0] rd_data_q;

  // Sign-magnitude back to two's complement.
  function automatic logic [MSIZE-1:0] to_tc(input logic [MSIZE-1:0] sm);
    logic [MSIZE-1:0] mag;
    mag = {1'b0, sm[MSIZE-2:0]};
    if (sm[MSIZE-1]) begin
      to_tc = -mag;
    end else begin
      to_tc = mag;
    end
  endfunction

  // Registered readback of the active bank; out-of-range indices read zero.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= {MSIZE{1'b0}};
    end else begin
      rd_data_q <= {MSIZE{1'b0}};
      for (int i = 0; i < 9; i++) begin
        if (rd_idx == 4'(i)) begin
          rd_data_q <= to_tc(active_q[i]);
        end
      end
    end
  end

  assign rd_data = rd_data_q;
`endif

  assign M00      = active_q[0];
  assign M01      = active_q[1];
  assign M02      = active_q[2];
  assign M10      = active_q[3];
  assign M11      = active_q[4];
  assign M12      = active_q[5];
  assign M20      = active_q[6];
  assign M21      = active_q[7];
  assign M22      = active_q[8];
  assign wr_ready = wr_ready_q;
  assign set_full = set_full_q;
  assign commit   = commit_q;
  assign sat_flag = sat_q;

endmodule

// File: doc/matrix_coef_loader.md
Name: matrix_coef_loader

Overview:
- Supplies the nine 3x3 colour-matrix coefficients (M00..M22) that feed the RGB matrix multiplier. This block is the writer/producer end of that coefficient interface.
- Accepts a serial stream of two's-complement coefficients through a valid/ready handshake and converts each one to the sign-magnitude format the multiplier consumes.
- Holds coefficients in a shadow bank. The shadow bank is committed to the active outputs only at a frame boundary, so the matrix never changes mid-frame.

Parameters:
MSIZE, 8, coefficient width (sign bit + MSIZE-1 magnitude bits), equal to the multiplier's MSIZE
DIAG_INIT, 8'h7F, sign-magnitude reset value for M00/M11/M22 (MSIZE bits)

Ports:
clock  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  coefficient write request
wr_ready  out  1  block can accept a coefficient this cycle
wr_data  in  MSIZE  coefficient, two's complement; order M00,M01,M02,M10,M11,M12,M20,M21,M22
wr_abort  in  1  discard partial/complete shadow set, restart at M00
frame_sync  in  1  one-cycle pulse at start of frame; commit point
M00..M22  out  MSIZE each (9 ports)  active coefficients, sign-magnitude: [MSIZE-1]=sign, [MSIZE-2:0]=magnitude
commit  out  1  one-cycle pulse, active bank updated this cycle
set_full  out  1  complete shadow set waiting for frame_sync
sat_flag  out  1  sticky: a -2^(MSIZE-1) input was saturated

Behaviour:
- Reset is asynchronous and active-low; every output is registered. Reset values:
  - M00, M11, M22 = DIAG_INIT; all other coefficients = 0.
  - commit = 0, set_full = 0, sat_flag = 0, wr_ready = 1.
  - State = IDLE, index = 0.
- A write is accepted on a rising edge where wr_valid && wr_ready. The converted value goes to shadow[index] and index increments.
- Conversion:
  - x >= 0 gives {0, x[MSIZE-2:0]}.
  - x < 0 gives {1, (-x)[MSIZE-2:0]}.
  - x = -2^(MSIZE-1) gives {1, all-ones} and sets sat_flag.
  - Zero always encodes as sign 0.
- States:
  - IDLE: index = 0. Accept moves to LOAD.
  - LOAD: index 1..8. An accept at index 8 moves to FULL; index returns to 0.
  - FULL: wr_ready = 0 and set_full = 1. On frame_sync, the active outputs load from the shadow bank on the same edge, commit = 1 the following cycle, and the state returns to IDLE.
- frame_sync in IDLE or LOAD has no effect: no commit, and loading continues.
- Accepting the 9th coefficient on the same edge as frame_sync does not commit. The set commits on the next frame_sync, because FULL must already be registered.
- wr_abort (any state): index goes to 0 and the state to IDLE. A write on the same cycle is dropped. If frame_sync occurs on the same cycle in FULL, abort wins and there is no commit. Active outputs are untouched.
- wr_ready is a registered function of state, never of wr_valid.
- sat_flag clears only on reset.
- Latency: frame_sync sampled on edge N gives new M** values visible after edge N, with commit high for the cycle after edge N.
- Active outputs change only on a commit or on reset.

Optional Feature:
MATRIX_COEF_READBACK_EN
- Defined: adds input rd_idx[3:0] and output rd_data[MSIZE-1:0].
  - rd_data is registered (1-cycle latency) and returns active coefficient rd_idx (0..8 in write order) converted back to two's complement.
  - rd_idx > 8 returns 0.
  - rd_data resets to 0.
- Undefined: the ports are absent and there is no added logic.

Test Plan:
- Release reset, hold inputs idle for 10 cycles: M00 = M11 = M22 = 8'h7F, others 0, commit never pulses, wr_ready = 1.
- Write 1,2,3,-1,-2,-3,0,127,-127 back-to-back, then wait 5 cycles:
  - set_full = 1, wr_ready = 0, outputs unchanged.
  - Pulse frame_sync: M01 = 8'h02, M10 = 8'h81, M12 = 8'h83, M21 = 8'h7F, M22 = 8'hFF, commit is a single pulse, state returns to IDLE.
- Write 4 coefficients, pulse frame_sync, then write the remaining 5 and pulse frame_sync again: the first pulse produces no commit; the second commits all 9 values.
- Write 6 coefficients, assert wr_abort together with wr_valid, then write 9 new values and pulse frame_sync: only the new set appears, and the aborted write is lost.
- Write 9th coefficient on the same edge as frame_sync: no commit; the next frame_sync commits. Write -128: stored as 8'hFF and sat_flag stays 1 until reset.
- Assert rst_n low mid-load (index 5) and asynchronously, away from any clock edge: outputs return to their reset values immediately. Readback (if MATRIX_COEF_READBACK_EN is defined): rd_idx = 3 after the second scenario gives 8'hFF one cycle later.
